// File: rtl/core_ctrl_if.sv
// Preload stream and core instruction bus shared by the sequencer and its host.
interface core_ctrl_if #(
  parameter int DW = 32
) ();

  // Preload stream (host -> sequencer)
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  // Core side
  logic          ofifo_valid;
  logic [33:0]   inst;
  logic [1:0]    inst_w;
  logic [DW-1:0] D_xmem;

  // Host / core environment view
  modport master (
    output in_valid, in_data, ofifo_valid,
    input  in_ready, inst, inst_w, D_xmem
  );

  // Sequencer view
  modport slave (
    input  in_valid, in_data, ofifo_valid,
    output in_ready, inst, inst_w, D_xmem
  );

endinterface

// File: rtl/core_ctrl.sv
// Layer sequencer for the core block: preloads xmem from a stream, then for each
// kernel position loads weights, streams activations, executes, drains the
// output FIFO, and finally runs the accumulate pass.
module core_ctrl #(
  parameter int bw       = 4,
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int nij_len  = 36,
  parameter int onij_len = 16,
  parameter int kij_len  = 9,
  parameter int W_BASE   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  core_ctrl_if.slave bus,
  output logic       busy,
  output logic       done
);

  localparam int DW         = row * bw;
  localparam int AW         = 11;
  localparam int XLOAD_LEN  = nij_len + kij_len * col;
  localparam int SETTLE_LEN = row + col;
  localparam int ACC_LEN    = onij_len * kij_len;
  // Wide enough for the longest phase of any kind.
  localparam int CW         = $clog2(XLOAD_LEN + ACC_LEN + SETTLE_LEN + 1);
  localparam int KW         = $clog2(kij_len + 1);

  // Instruction bit positions
  localparam int B_ACC   = 33;
  localparam int B_CEN_P = 32;
  localparam int B_CEN_X = 19;
  localparam int B_WEN_X = 18;
  localparam int B_L0RD  = 3;
  localparam int B_L0WR  = 2;
  localparam int B_EXEC  = 1;
  localparam int B_LOAD  = 0;

  // Both SRAMs disabled with write-enable inactive.
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  if (nij_len == 0 || kij_len == 0) begin : g_bad_len
    $error("core_ctrl: nij_len and kij_len must be non-zero");
  end
  if (W_BASE + kij_len * col > 2048) begin : g_bad_wbase
    $error("core_ctrl: weight region exceeds the 11-bit xmem address space");
  end

  typedef enum logic [3:0] {
    IDLE, XLOAD, WREAD, WLOAD, WSETTLE, AREAD, EXEC, DRAIN, ACC, FIN
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   kij, kij_nxt;
  logic [33:0]     inst_q, inst_nxt;
  logic [DW-1:0]   d_q, d_nxt;
  logic            in_ready_q, in_ready_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;

  logic            accept;
  logic            last_was_read;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   w_addr;

  function automatic logic at_end(input logic [CW-1:0] c, input int len);
    return c == CW'(len - 1);
  endfunction

  assign accept        = bus.in_valid & in_ready_q;
  // The word currently on the bus is an xmem read; l0 captures its data next cycle.
  assign last_was_read = ~inst_q[B_CEN_X] & inst_q[B_WEN_X];
  assign wr_ptr = (int'(cnt) < nij_len) ? AW'(cnt) : AW'(W_BASE + int'(cnt) - nij_len);
  assign w_addr = AW'(W_BASE + int'(kij) * col + int'(cnt));

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_nxt          = state;
    cnt_nxt            = cnt;
    kij_nxt            = kij;
    inst_nxt           = IDLE_WORD;
    inst_nxt[B_L0WR]   = last_was_read;
    d_nxt              = d_q;
    done_nxt           = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) state_nxt = XLOAD;
      end
      XLOAD: begin
        if (accept) begin
          inst_nxt[B_CEN_X] = 1'b0;
          inst_nxt[B_WEN_X] = 1'b0;
          inst_nxt[17:7]    = wr_ptr;
          d_nxt             = bus.in_data;
          if (at_end(cnt, XLOAD_LEN)) begin
            cnt_nxt   = '0;
            kij_nxt   = '0;
            state_nxt = WREAD;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      WREAD: begin
        inst_nxt[B_CEN_X] = 1'b0;
        inst_nxt[17:7]    = w_addr;
        if (at_end(cnt, col)) begin
          cnt_nxt   = '0;
          state_nxt = WLOAD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WLOAD: begin
        inst_nxt[B_L0RD] = 1'b1;
        inst_nxt[B_LOAD] = 1'b1;
        if (at_end(cnt, col)) begin
          cnt_nxt   = '0;
          state_nxt = WSETTLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WSETTLE: begin
        if (at_end(cnt, SETTLE_LEN)) begin
          cnt_nxt   = '0;
          state_nxt = AREAD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      AREAD: begin
        inst_nxt[B_CEN_X] = 1'b0;
        inst_nxt[17:7]    = AW'(cnt);
        if (at_end(cnt, nij_len)) begin
          cnt_nxt   = '0;
          state_nxt = EXEC;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      EXEC: begin
        inst_nxt[B_L0RD] = 1'b1;
        inst_nxt[B_EXEC] = 1'b1;
        if (at_end(cnt, nij_len)) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.ofifo_valid) begin
          if (at_end(cnt, nij_len)) begin
            cnt_nxt   = '0;
            kij_nxt   = kij + 1'b1;
            state_nxt = (int'(kij) + 1 < kij_len) ? WREAD : ACC;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ACC: begin
        inst_nxt[B_ACC]   = 1'b1;
        inst_nxt[B_CEN_P] = 1'b0;
        if (at_end(cnt, ACC_LEN)) begin
          cnt_nxt   = '0;
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FIN: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt = (state_nxt == XLOAD);
    busy_nxt     = (state_nxt != IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      kij        <= '0;
      inst_q     <= IDLE_WORD;
      d_q        <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      kij        <= kij_nxt;
      inst_q     <= inst_nxt;
      d_q        <= d_nxt;
      in_ready_q <= in_ready_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  // ofifo_rd is the only combinational output: it follows ofifo_valid while draining.
  assign bus.inst     = inst_q | {27'd0, (state == DRAIN) & bus.ofifo_valid, 6'd0};
  assign bus.inst_w   = inst_q[1:0];
  assign bus.D_xmem   = d_q;
  assign bus.in_ready = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: stimulus pushes expected instruction events,
// a negedge monitor pops and compares every non-idle word (and done).
module tb_core_ctrl;

  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int NIJ   = 36;
  localparam int ONIJ  = 16;
  localparam int KIJ   = 9;
  localparam int WBASE = 1024;
  localparam int DW    = ROW * BW;
  localparam int TOTAL = NIJ + KIJ * COL;

  localparam logic [33:0] B_ACC   = 34'd1 << 33;
  localparam logic [33:0] B_CENP  = 34'd1 << 32;
  localparam logic [33:0] B_WENP  = 34'd1 << 31;
  localparam logic [33:0] B_CENX  = 34'd1 << 19;
  localparam logic [33:0] B_WENX  = 34'd1 << 18;
  localparam logic [33:0] B_OFIFO = 34'd1 << 6;
  localparam logic [33:0] B_L0RD  = 34'd1 << 3;
  localparam logic [33:0] B_L0WR  = 34'd1 << 2;
  localparam logic [33:0] B_EXEC  = 34'd1 << 1;
  localparam logic [33:0] B_LOAD  = 34'd1 << 0;
  localparam logic [33:0] IDLE_W  = B_CENP | B_WENP | B_CENX | B_WENX;

  typedef struct {
    logic [33:0]   word;
    logic [DW-1:0] data;
    bit            chk_data;
    int            gap;   // idle cycles before this event, -1 = don't care
    bit            done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  core_ctrl_if #(.DW(DW)) bus ();

  core_ctrl #(
    .bw(BW), .row(ROW), .col(COL), .nij_len(NIJ),
    .onij_len(ONIJ), .kij_len(KIJ), .W_BASE(WBASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   idle_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] rd_word(input int addr);
    return (IDLE_W & ~B_CENX) | (34'(addr) << 7);
  endfunction

  function automatic logic [33:0] wr_word(input int addr);
    return (IDLE_W & ~B_CENX & ~B_WENX) | (34'(addr) << 7);
  endfunction

  function automatic int addr_of(input int i);
    return (i < NIJ) ? i : WBASE + i - NIJ;
  endfunction

  function automatic logic [DW-1:0] pdata(input int i, input int seed);
    return (32'(seed) * 32'h0100_0193) ^ {8'(i), 8'(~i), 8'(i * 7), 8'(i + seed)};
  endfunction

  task automatic push(input logic [33:0] w, input logic [DW-1:0] d, input bit cd,
                      input int gap, input bit dn);
    exp_t e;
    e.word = w; e.data = d; e.chk_data = cd; e.gap = gap; e.done = dn;
    sb_q.push_back(e);
  endtask

  // Expected events of a layer after the preload.
  task automatic push_tail();
    for (int k = 0; k < KIJ; k++) begin
      for (int c = 0; c < COL; c++)
        push(rd_word(WBASE + k * COL + c) | ((c > 0) ? B_L0WR : 34'd0), '0, 1'b0,
             (c == 0) ? ((k == 0) ? 0 : -1) : 0, 1'b0);
      for (int c = 0; c < COL; c++)
        push(IDLE_W | B_L0RD | B_LOAD | ((c == 0) ? B_L0WR : 34'd0), '0, 1'b0, 0, 1'b0);
      for (int a = 0; a < NIJ; a++)
        push(rd_word(a) | ((a > 0) ? B_L0WR : 34'd0), '0, 1'b0, (a == 0) ? ROW + COL : 0, 1'b0);
      for (int e = 0; e < NIJ; e++)
        push(IDLE_W | B_L0RD | B_EXEC | ((e == 0) ? B_L0WR : 34'd0), '0, 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < ONIJ * KIJ; i++)
      push((IDLE_W & ~B_CENP) | B_ACC, '0, 1'b0, (i == 0) ? -1 : 0, 1'b0);
    push(IDLE_W, '0, 1'b0, 0, 1'b1);
  endtask

  // Monitor: compares every non-idle instruction word (and done) against the queue.
  always @(negedge clk) begin
    exp_t        e;
    logic [33:0] w;
    if (!mon_en) begin
      idle_run = 0;
    end else begin
      check("ofifo_rd", bus.inst[6], bus.ofifo_valid);
      check("inst_w", bus.inst_w, bus.inst[1:0]);
      w = bus.inst & ~B_OFIFO;
      if (w != IDLE_W || done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got inst 0x%0h done %0b, want none at %0t", w, done, $time);
        end else begin
          e = sb_q.pop_front();
          check("inst_word", w, e.word);
          check("done", done, e.done);
          if (e.chk_data) check("d_xmem", bus.D_xmem, e.data);
          if (e.gap >= 0) check("idle_gap", idle_run, e.gap);
          if (e.done) check("busy_at_done", busy, 0);
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams TOTAL words; toggle=1 offers a word only every other ready cycle.
  task automatic preload(input bit toggle, input int seed);
    int            sent = 0;
    int            idle_cnt = -1;
    bit            phase = 1'b1;
    logic [DW-1:0] d;
    for (int cyc = 0; cyc < 1000 && sent < TOTAL; cyc++) begin
      if (bus.in_ready && (!toggle || phase)) begin
        d = pdata(sent, seed);
        push(wr_word(addr_of(sent)), d, 1'b1, idle_cnt, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        sent++;
        idle_cnt = 0;
        if (sent == TOTAL) push_tail();
      end else begin
        bus.in_valid = 1'b0;
        if (idle_cnt >= 0 && bus.in_ready) idle_cnt++;
      end
      if (bus.in_ready) phase = ~phase;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("preload_count", sent, TOTAL);
    check("in_ready_drop", bus.in_ready, 0);
  endtask

  task automatic wait_bit(input int b, input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.inst[b] === v) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_inst_bit", ok, 1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_inst", bus.inst, IDLE_W);
    check("rst_inst_w", bus.inst_w, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_done", done, 0);
    check("rst_d_xmem", bus.D_xmem, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // Per kernel position: wait for execute, then answer the drain with gapped ofifo_valid.
  task automatic run_drains(input int abort_kij, input int start_kij);
    bit ok;
    for (int k = 0; k < KIJ; k++) begin
      wait_bit(1, 1'b1, 600, ok);
      if (!ok) return;
      if (k == abort_kij) begin
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        return;
      end
      if (k == start_kij) pulse_start();
      wait_bit(1, 1'b0, 100, ok);
      if (!ok) return;
      for (int i = 0; i < NIJ; i++) begin
        repeat ((i * 5 + k * 3) % 4) begin
          @(posedge clk); #1;
        end
        bus.ofifo_valid = 1'b1;
        @(posedge clk); #1;
        bus.ofifo_valid = 1'b0;
      end
    end
  endtask

  // Counts accumulate words; a start pulse lands on the FIN cycle and must be ignored.
  task automatic finish_layer();
    int accs = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (bus.inst[33]) accs++;
      if (accs == ONIJ * KIJ) begin
        ok = 1'b1;
        break;
      end
    end
    check("acc_cycles", ok, 1);
    if (ok) begin
      pulse_start();
      @(posedge clk); #1;
      check("fin_start_busy", busy, 0);
      check("fin_start_in_ready", bus.in_ready, 0);
    end
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_inst", bus.inst, IDLE_W);
      check("idle_busy", busy, 0);
      check("idle_in_ready", bus.in_ready, 0);
    end
    check("idle_d_xmem", bus.D_xmem, 0);
    @(posedge clk); #1;

    // Layer A: back-to-back preload, stray start during execute, start on FIN
    pulse_start();
    preload(1'b0, 1);
    run_drains(-1, 1);
    finish_layer();

    // Layer B: bubbled preload, aborted by reset during execute of kij 4
    pulse_start();
    preload(1'b1, 2);
    run_drains(4, -1);

    // Layer C: full replay after the abort
    pulse_start();
    preload(1'b0, 3);
    run_drains(-1, -1);
    finish_layer();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
